// File: rtl/audio_pkg.sv
// Shared constants and saturation helper for the PDM/PWM audio paths.
package audio_pkg;

    localparam int SAMPLE_W   = 16;
    localparam int RAM_ADDR_W = 11;

    localparam logic BANK_PING = 1'b0;
    localparam logic BANK_PONG = 1'b1;

    localparam logic signed [SAMPLE_W-1:0] SAT_MAX = 16'sh7FFF;
    localparam logic signed [SAMPLE_W-1:0] SAT_MIN = 16'sh8000;

    // Clamp a 24-bit signed intermediate into the 16-bit sample range.
    function automatic logic signed [SAMPLE_W-1:0] sat16(input logic signed [23:0] v);
        if (v > 24'(SAT_MAX)) begin
            return SAT_MAX;
        end else if (v < 24'(SAT_MIN)) begin
            return SAT_MIN;
        end
        return v[SAMPLE_W-1:0];
    endfunction

endpackage

// File: rtl/pdm_deserializer.sv
// PDM clock divider, input synchronizer and boxcar decimator producing
// saturated signed samples with a one-cycle sample_valid pulse.
module pdm_deserializer
    import audio_pkg::*;
#(
    parameter int PDM_CLK_DIV = 20,
    parameter int DECIM       = 64,
    parameter int GAIN_SHIFT  = 9
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       pdm_data,
    output logic                       pdm_clk,
    output logic signed [SAMPLE_W-1:0] sample,
    output logic                       sample_valid
);

    logic [7:0]                 div_q, div_d;
    logic                       pdm_clk_q, pdm_clk_d;
    logic                       sync1_q, sync2_q;
    logic [7:0]                 cnt_q, cnt_d;
    logic [7:0]                 acc_q, acc_d;
    logic signed [SAMPLE_W-1:0] sample_q, sample_d;
    logic                       valid_q, valid_d;
    logic [7:0]                 ones;
    logic signed [23:0]         centred;

    always_comb begin
        div_d     = div_q;
        pdm_clk_d = pdm_clk_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        sample_d  = sample_q;
        valid_d   = 1'b0;
        ones      = acc_q + {7'd0, sync2_q};
        centred   = signed'((24'(ones) << 1) - 24'(DECIM)) <<< GAIN_SHIFT;

        if (!en) begin
            pdm_clk_d = 1'b0;
            cnt_d     = '0;
            acc_d     = '0;
        end else if (div_q == 8'(PDM_CLK_DIV - 1)) begin
            div_d     = '0;
            pdm_clk_d = ~pdm_clk_q;
            // The mic bit is taken on the cycle the clock is driven low.
            if (pdm_clk_q) begin
                if (cnt_q == 8'(DECIM - 1)) begin
                    cnt_d    = '0;
                    acc_d    = '0;
                    sample_d = sat16(centred);
                    valid_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    acc_d = ones;
                end
            end
        end else begin
            div_d = div_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q     <= '0;
            pdm_clk_q <= 1'b0;
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            cnt_q     <= '0;
            acc_q     <= '0;
            sample_q  <= '0;
            valid_q   <= 1'b0;
        end else begin
            div_q     <= div_d;
            pdm_clk_q <= pdm_clk_d;
            sync1_q   <= pdm_data;
            sync2_q   <= sync1_q;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            sample_q  <= sample_d;
            valid_q   <= valid_d;
        end
    end

    assign pdm_clk      = pdm_clk_q;
    assign sample       = sample_q;
    assign sample_valid = valid_q;

endmodule

// File: rtl/pdm_mic_capture.sv
// PDM microphone capture: decimated samples written to ping/pong banks with a
// ready/ack bank handshake. Define PDM_MIC_DC_BLOCK_EN to add a DC-blocking stage.
module pdm_mic_capture
    import audio_pkg::*;
#(
    parameter int SYS_CLK_FREQ_MHZ = 100,
    parameter int PDM_CLK_DIV      = 20,
    parameter int DECIM            = 64,
    parameter int GAIN_SHIFT       = 9,
    parameter int DATA_WIDTH       = 16,
    parameter int BANK_AW          = RAM_ADDR_W
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  EN,
    output logic                  PDM_CLK,
    output logic                  PDM_LRSEL,
    input  logic                  PDM_DATA,
    output logic [RAM_ADDR_W-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic                  ping_we,
    output logic                  pong_we,
    output logic                  buf_ready,
    output logic                  buf_bank,
    input  logic                  buf_ack,
    output logic                  overrun
);

    localparam logic [RAM_ADDR_W-1:0] LAST_ADDR = RAM_ADDR_W'((1 << BANK_AW) - 1);

    if (SYS_CLK_FREQ_MHZ <= 0 || PDM_CLK_DIV < 4 || PDM_CLK_DIV > 255) begin : g_bad_clk
        $error("pdm_mic_capture: illegal clock parameters");
    end
    if (DECIM < 16 || DECIM > 128 || (DECIM & (DECIM - 1)) != 0) begin : g_bad_decim
        $error("pdm_mic_capture: DECIM must be a power of two in 16..128");
    end
    if (DATA_WIDTH != SAMPLE_W || BANK_AW < 1 || BANK_AW > RAM_ADDR_W) begin : g_bad_width
        $error("pdm_mic_capture: illegal width parameters");
    end

    logic signed [SAMPLE_W-1:0] ds_sample, st_sample;
    logic                       ds_valid, st_valid;

    pdm_deserializer #(
        .PDM_CLK_DIV (PDM_CLK_DIV),
        .DECIM       (DECIM),
        .GAIN_SHIFT  (GAIN_SHIFT)
    ) u_deser (
        .clk          (HCLK),
        .rst          (HRESET),
        .en           (EN),
        .pdm_data     (PDM_DATA),
        .pdm_clk      (PDM_CLK),
        .sample       (ds_sample),
        .sample_valid (ds_valid)
    );

`ifdef PDM_MIC_DC_BLOCK_EN
    logic signed [SAMPLE_W-1:0] x_prev_q, x_prev_d, y_prev_q, y_prev_d, hp_q, hp_d;
    logic                       hp_valid_q, hp_valid_d;
    logic signed [19:0]         y_full;

    // y = x - x_prev + y_prev - y_prev/256, a pole just inside z = 1.
    always_comb begin
        x_prev_d   = x_prev_q;
        y_prev_d   = y_prev_q;
        hp_d       = hp_q;
        hp_valid_d = 1'b0;
        y_full     = 20'(ds_sample) - 20'(x_prev_q) + 20'(y_prev_q) - 20'(y_prev_q >>> 8);
        if (!EN) begin
            x_prev_d = '0;
            y_prev_d = '0;
        end else if (ds_valid) begin
            hp_d       = sat16(24'(y_full));
            x_prev_d   = ds_sample;
            y_prev_d   = hp_d;
            hp_valid_d = 1'b1;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            x_prev_q   <= '0;
            y_prev_q   <= '0;
            hp_q       <= '0;
            hp_valid_q <= 1'b0;
        end else begin
            x_prev_q   <= x_prev_d;
            y_prev_q   <= y_prev_d;
            hp_q       <= hp_d;
            hp_valid_q <= hp_valid_d;
        end
    end

    assign st_sample = hp_q;
    assign st_valid  = hp_valid_q;
`else
    assign st_sample = ds_sample;
    assign st_valid  = ds_valid;
`endif

    logic [BANK_AW:0]        idx_q, idx_d;
    logic [RAM_ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic [DATA_WIDTH-1:0]   ram_wdata_q, ram_wdata_d;
    logic                    ping_we_q, ping_we_d, pong_we_q, pong_we_d;
    logic                    buf_ready_q, buf_ready_d, buf_bank_q, buf_bank_d;
    logic                    overrun_q, overrun_d;
    logic                    complete;

    // Handshake: buf_ready holds until the consumer pulses buf_ack; an ack while
    // buf_ready=0 is ignored, and a bank completing in the ack cycle keeps buf_ready set.
    always_comb begin
        idx_d       = idx_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        ping_we_d   = 1'b0;
        pong_we_d   = 1'b0;
        buf_ready_d = buf_ready_q;
        buf_bank_d  = buf_bank_q;
        overrun_d   = overrun_q;
        complete    = (ping_we_q || pong_we_q) && (ram_addr_q == LAST_ADDR);

        if (st_valid) begin
            ram_addr_d  = RAM_ADDR_W'(idx_q[BANK_AW-1:0]);
            ram_wdata_d = DATA_WIDTH'(st_sample);
            ping_we_d   = (idx_q[BANK_AW] == BANK_PING);
            pong_we_d   = (idx_q[BANK_AW] == BANK_PONG);
            idx_d       = idx_q + 1'b1;
        end

        if (complete) begin
            buf_ready_d = 1'b1;
            buf_bank_d  = pong_we_q ? BANK_PONG : BANK_PING;
            if (buf_ready_q && !buf_ack) begin
                overrun_d = 1'b1;
            end
        end else if (buf_ack && buf_ready_q) begin
            buf_ready_d = 1'b0;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            idx_q       <= '0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ping_we_q   <= 1'b0;
            pong_we_q   <= 1'b0;
            buf_ready_q <= 1'b0;
            buf_bank_q  <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            idx_q       <= idx_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            ping_we_q   <= ping_we_d;
            pong_we_q   <= pong_we_d;
            buf_ready_q <= buf_ready_d;
            buf_bank_q  <= buf_bank_d;
            overrun_q   <= overrun_d;
        end
    end

    assign PDM_LRSEL = 1'b0;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign ping_we   = ping_we_q;
    assign pong_we   = pong_we_q;
    assign buf_ready = buf_ready_q;
    assign buf_bank  = buf_bank_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_pdm_mic_capture.sv
// Bench for pdm_mic_capture with shortened clock divider, window and bank depth.
module tb_pdm_mic_capture;

    localparam int DIV  = 4;
    localparam int DEC  = 16;
    localparam int GAIN = 11;
    localparam int BAW  = 4;
    localparam logic [10:0] LAST = 11'((1 << BAW) - 1);

    logic        HCLK = 1'b0;
    logic        HRESET, EN, PDM_DATA, buf_ack;
    logic        PDM_CLK, PDM_LRSEL, ping_we, pong_we, buf_ready, buf_bank, overrun;
    logic [10:0] ram_addr;
    logic [15:0] ram_wdata;

    pdm_mic_capture #(
        .PDM_CLK_DIV (DIV),
        .DECIM       (DEC),
        .GAIN_SHIFT  (GAIN),
        .BANK_AW     (BAW)
    ) dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .EN        (EN),
        .PDM_CLK   (PDM_CLK),
        .PDM_LRSEL (PDM_LRSEL),
        .PDM_DATA  (PDM_DATA),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ping_we   (ping_we),
        .pong_we   (pong_we),
        .buf_ready (buf_ready),
        .buf_bank  (buf_bank),
        .buf_ack   (buf_ack),
        .overrun   (overrun)
    );

    always #5 HCLK = ~HCLK;

    int vectors = 0;
    int miscompares = 0;

    logic        bit_q[$];
    logic [28:0] exp_q[$];
    logic [BAW:0] m_idx;
    logic [15:0] pats[7] = '{16'hFFFF, 16'h0000, 16'hAAAA, 16'h5555,
                             16'h0FFF, 16'h0001, 16'h7FFF};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] model_sample(input logic [15:0] bits);
        int v;
        v = (2 * $countones(bits) - DEC) * (1 << GAIN);
        if (v > 32767) v = 32767;
        if (v < -32768) v = -32768;
        return 16'(v);
    endfunction

    // Queue one window of mic bits plus the strobe it should produce.
    task automatic queue_sample(input logic [15:0] bits);
        for (int i = 0; i < DEC; i++) bit_q.push_back(bits[i]);
        exp_q.push_back({~m_idx[BAW], m_idx[BAW], 11'(m_idx[BAW-1:0]), model_sample(bits)});
        m_idx++;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_pdm_clk"}, PDM_CLK, 0);
        check({tag, "_lrsel"}, PDM_LRSEL, 0);
        check({tag, "_addr"}, ram_addr, 0);
        check({tag, "_wdata"}, ram_wdata, 0);
        check({tag, "_we"}, {ping_we, pong_we}, 0);
        check({tag, "_ready"}, buf_ready, 0);
        check({tag, "_bank"}, buf_bank, 0);
        check({tag, "_overrun"}, overrun, 0);
    endtask

    task automatic wait_last(input logic bank, input int budget, output logic found);
        found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            @(posedge HCLK); #1;
            if ((bank ? pong_we : ping_we) && ram_addr == LAST) found = 1'b1;
        end
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge HCLK); #1;
            n++;
        end
        check(tag, exp_q.size(), 0);
    endtask

    // Mic model: a new bit appears just after each rising PDM_CLK edge.
    initial begin
        logic prev;
        PDM_DATA = 1'b0;
        prev = 1'b0;
        forever begin
            @(posedge HCLK); #1;
            if (PDM_CLK && !prev) PDM_DATA = (bit_q.size() != 0) ? bit_q.pop_front() : 1'b1;
            prev = PDM_CLK;
        end
    end

    // Scoreboard: every strobe pops one expected {ping, pong, addr, data}.
    initial begin
        logic [28:0] exp;
        logic        pend_cmp;
        logic        pend_bank;
        pend_cmp = 1'b0;
        pend_bank = 1'b0;
        forever begin
            @(negedge HCLK);
            if (pend_cmp) begin
                check("cmp_ready", buf_ready, 1);
                check("cmp_bank", buf_bank, 32'(pend_bank));
                pend_cmp = 1'b0;
            end
            if (ping_we || pong_we) begin
                exp = (exp_q.size() != 0) ? exp_q.pop_front() : 29'd0;
                check("strobe", {ping_we, pong_we, ram_addr, ram_wdata}, exp);
                if (exp[26:16] == LAST && exp[28:27] != 2'b00) begin
                    pend_cmp = 1'b1;
                    pend_bank = exp[27];
                end
            end
        end
    end

    initial begin
        logic found;
        logic bad;
        int   n;

        HRESET = 1'b1;
        EN = 1'b0;
        buf_ack = 1'b0;
        m_idx = '0;
        repeat (3) @(posedge HCLK);
        #1;
        check_reset_values("reset");

        // Banks 0..2 in full, then ten samples into bank 3.
        for (int s = 0; s < 58; s++) begin
            if (s < 7) queue_sample(pats[s]);
            else queue_sample(16'($urandom_range(0, 65535)));
        end
        HRESET = 1'b0;
        EN = 1'b1;

        wait_last(1'b0, 3000, found);
        check("wait_bank0", found, 1);
        @(posedge HCLK); #1;
        check("bank0_overrun", overrun, 0);

        wait_last(1'b1, 3000, found);
        check("wait_bank1", found, 1);
        buf_ack = 1'b1;
        @(posedge HCLK); #1;
        buf_ack = 1'b0;
        check("ack_at_cmp_ready", buf_ready, 1);
        check("ack_at_cmp_bank", buf_bank, 1);
        check("ack_at_cmp_overrun", overrun, 0);

        wait_last(1'b0, 3000, found);
        check("wait_bank2", found, 1);
        @(posedge HCLK); #1;
        check("ovr_set", overrun, 1);
        check("ovr_ready", buf_ready, 1);
        check("ovr_bank", buf_bank, 0);
        buf_ack = 1'b1;
        @(posedge HCLK); #1;
        buf_ack = 1'b0;
        check("ack_clears_ready", buf_ready, 0);
        check("ovr_sticky", overrun, 1);

        wait_drain("drain_bank3", 3000);
        HRESET = 1'b1;
        @(posedge HCLK); #1;
        check_reset_values("midbank_reset");
        m_idx = '0;
        for (int s = 0; s < 3; s++) queue_sample(16'($urandom_range(0, 65535)));
        @(posedge HCLK); #1;
        HRESET = 1'b0;
        wait_drain("drain_post_reset", 1500);

        // Disable just after a falling PDM_CLK edge, mid-window.
        found = 1'b0;
        bad = PDM_CLK;
        for (int i = 0; i < 50 && !found; i++) begin
            @(posedge HCLK); #1;
            if (bad && !PDM_CLK) found = 1'b1;
            bad = PDM_CLK;
        end
        check("wait_fall", found, 1);
        EN = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(posedge HCLK); #1;
            if (PDM_CLK || ping_we || pong_we) bad = 1'b1;
        end
        check("en_off_quiet", bad, 0);

        queue_sample(16'h00FF);
        queue_sample(16'h0F0F);
        EN = 1'b1;
        n = 0;
        found = 1'b0;
        while (!found && n < 1000) begin
            @(posedge HCLK); #1;
            n++;
            if (ping_we || pong_we) found = 1'b1;
        end
        check("reenable_latency", n, 2 * DIV * DEC + 1);
        n = 0;
        found = 1'b0;
        while (!found && n < 1000) begin
            @(posedge HCLK); #1;
            n++;
            if (ping_we || pong_we) found = 1'b1;
        end
        check("sample_period", n, 2 * DIV * DEC);
        wait_drain("drain_final", 300);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
